// File: rtl/ysyx_22041071_div_ctrl_pkg.sv
// Shared state and opcode encodings for the divider sequencing controller.
package ysyx_22041071_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22041071_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined result for those cases.
module ysyx_22041071_div_special
    import ysyx_22041071_div_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            hit,
    output logic [XLEN-1:0] result
);

    logic            div0_s;
    logic            ovf_s;
    logic [XLEN-1:0] raw_s;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Detect the special cases on the operand width actually in use
    always_comb begin
        if (word) begin
            div0_s = (src2[31:0] == 32'd0);
            ovf_s  = op_is_signed(op) && (src1[31:0] == 32'h8000_0000) &&
                     (src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            div0_s = (src2 == {XLEN{1'b0}});
            ovf_s  = op_is_signed(op) && (src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (src2 == {XLEN{1'b1}});
        end
    end

    // Quotient is all ones (div0) or the dividend (ovf); remainder is the
    // dividend (div0) or zero (ovf)
    always_comb begin
        if (op_is_rem(op)) begin
            raw_s = div0_s ? src1 : {XLEN{1'b0}};
        end else begin
            raw_s = div0_s ? {XLEN{1'b1}} : src1;
        end
        if (word) begin
            result = sext_w(raw_s[31:0]);
        end else begin
            result = raw_s;
        end
        hit = div0_s || ovf_s;
    end

endmodule

// File: rtl/ysyx_22041071_div_ctrl.sv
// Sequencing controller between the EXU and the iterative divider.
// Optional one-entry result cache enabled by YSYX_22041071_DIV_REUSE_EN.
module ysyx_22041071_div_ctrl
    import ysyx_22041071_div_ctrl_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic [TAGW-1:0] req_tag,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [TAGW-1:0] resp_tag,
    output logic            dv_valid,
    output logic            dv_signed,
    output logic            dv_w,
    output logic [XLEN-1:0] dv_dividend,
    output logic [XLEN-1:0] dv_divisor,
    output logic            dv_flush,
    input  logic            dv_ready,
    input  logic            dv_out_valid,
    input  logic [XLEN-1:0] dv_quot,
    input  logic [XLEN-1:0] dv_rema,
    output logic            busy
);

    state_e          state_r;
    state_e          state_nxt_s;
    logic            req_ready_s;
    logic            accept_s;
    logic            wait_done_s;
    logic            sp_hit_s;
    logic [XLEN-1:0] sp_result_s;
    logic            reuse_hit_s;
    logic [XLEN-1:0] reuse_result_s;
    logic [XLEN-1:0] div_raw_s;
    logic [XLEN-1:0] div_result_s;

    logic [1:0]      op_r;
    logic            word_r;
    logic            signed_r;
    logic [XLEN-1:0] src1_r;
    logic [XLEN-1:0] src2_r;
    logic [TAGW-1:0] tag_r;
    logic [XLEN-1:0] resp_data_r;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    ysyx_22041071_div_special #(.XLEN(XLEN)) u_special (
        .op     (req_op),
        .word   (req_word),
        .src1   (req_src1),
        .src2   (req_src2),
        .hit    (sp_hit_s),
        .result (sp_result_s)
    );

    // Ready is withheld during reset so nothing is accepted before release
    assign req_ready_s = reset && (state_r == ST_IDLE) && !flush;
    assign accept_s    = req_valid && req_ready_s;
    assign wait_done_s = (state_r == ST_WAIT) && !flush && dv_out_valid;

`ifdef YSYX_22041071_DIV_REUSE_EN
    logic            cache_valid_r;
    logic [XLEN-1:0] cache_src1_r;
    logic [XLEN-1:0] cache_src2_r;
    logic            cache_signed_r;
    logic            cache_word_r;
    logic [XLEN-1:0] cache_quot_r;
    logic [XLEN-1:0] cache_rema_r;

    // Key match against the last completed divider operation
    always_comb begin
        reuse_hit_s = cache_valid_r && (req_src1 == cache_src1_r) &&
                      (req_src2 == cache_src2_r) &&
                      (op_is_signed(req_op) == cache_signed_r) &&
                      (req_word == cache_word_r);
        if (op_is_rem(req_op)) begin
            reuse_result_s = cache_rema_r;
        end else begin
            reuse_result_s = cache_quot_r;
        end
    end

    // Only divider results that reach RESP are cached; drained ones are not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid_r  <= 1'b0;
            cache_src1_r   <= {XLEN{1'b0}};
            cache_src2_r   <= {XLEN{1'b0}};
            cache_signed_r <= 1'b0;
            cache_word_r   <= 1'b0;
            cache_quot_r   <= {XLEN{1'b0}};
            cache_rema_r   <= {XLEN{1'b0}};
        end else if (wait_done_s) begin
            cache_valid_r  <= 1'b1;
            cache_src1_r   <= src1_r;
            cache_src2_r   <= src2_r;
            cache_signed_r <= signed_r;
            cache_word_r   <= word_r;
            cache_quot_r   <= dv_quot;
            cache_rema_r   <= dv_rema;
        end
    end
`else
    assign reuse_hit_s    = 1'b0;
    assign reuse_result_s = {XLEN{1'b0}};
`endif

    // Select quotient or remainder; W results are always sign-extended
    always_comb begin
        if (op_is_rem(op_r)) begin
            div_raw_s = dv_rema;
        end else begin
            div_raw_s = dv_quot;
        end
        if (word_r) begin
            div_result_s = sext_w(div_raw_s[31:0]);
        end else begin
            div_result_s = div_raw_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush has priority over completion and handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sp_hit_s || reuse_hit_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else if (dv_out_valid) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (dv_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request latch and result capture; operands stay frozen through WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r        <= 2'd0;
            word_r      <= 1'b0;
            signed_r    <= 1'b0;
            src1_r      <= {XLEN{1'b0}};
            src2_r      <= {XLEN{1'b0}};
            tag_r       <= {TAGW{1'b0}};
            resp_data_r <= {XLEN{1'b0}};
        end else begin
            if (accept_s) begin
                op_r     <= req_op;
                word_r   <= req_word;
                signed_r <= op_is_signed(req_op);
                src1_r   <= req_src1;
                src2_r   <= req_src2;
                tag_r    <= req_tag;
            end
            if (accept_s && sp_hit_s) begin
                resp_data_r <= sp_result_s;
            end else if (accept_s && reuse_hit_s) begin
                resp_data_r <= req_word ? sext_w(reuse_result_s[31:0]) : reuse_result_s;
            end else if (wait_done_s) begin
                resp_data_r <= div_result_s;
            end
        end
    end

    assign req_ready   = req_ready_s;
    assign resp_valid  = (state_r == ST_RESP);
    assign resp_data   = resp_data_r;
    assign resp_tag    = tag_r;
    assign dv_valid    = (state_r == ST_WAIT) && !flush;
    assign dv_flush    = (state_r == ST_WAIT) && flush;
    assign dv_signed   = signed_r;
    assign dv_w        = word_r;
    assign dv_dividend = src1_r;
    assign dv_divisor  = src2_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// Scoreboard bench for ysyx_22041071_div_ctrl with a behavioural divider model.
module tb_ysyx_22041071_div_ctrl;

    localparam int XLEN = 64;
    localparam int TAGW = 5;
    localparam int LAT  = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = 2'd0;
    logic            req_word = 1'b0;
    logic [XLEN-1:0] req_src1 = 64'd0;
    logic [XLEN-1:0] req_src2 = 64'd0;
    logic [TAGW-1:0] req_tag = 5'd0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_data;
    logic [TAGW-1:0] resp_tag;
    logic            dv_valid, dv_signed, dv_w, dv_flush;
    logic [XLEN-1:0] dv_dividend, dv_divisor;
    logic            dv_ready, dv_out_valid;
    logic [XLEN-1:0] dv_quot, dv_rema;
    logic            busy;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dv_cycles = 0;

    ysyx_22041071_div_ctrl #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
        .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag), .dv_valid(dv_valid),
        .dv_signed(dv_signed), .dv_w(dv_w), .dv_dividend(dv_dividend),
        .dv_divisor(dv_divisor), .dv_flush(dv_flush), .dv_ready(dv_ready),
        .dv_out_valid(dv_out_valid), .dv_quot(dv_quot), .dv_rema(dv_rema),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference RV64M division used by the divider model
    function automatic logic [127:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic sgn, input logic w);
        logic [63:0] q, r;
        logic [31:0] q32, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        if (w) begin
            if (b[31:0] == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'd0;
            end else if (sgn) begin
                sa32 = a[31:0]; sb32 = b[31:0];
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a; r = 64'd0;
            end else if (sgn) begin
                sa = a; sb = b;
                q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
        end
        return {q, r};
    endfunction

    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} dstate_e;
    dstate_e d_state;
    int      d_cnt;

    // Divider model: launches from IDLE, runs LAT cycles, one DONE cycle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_state <= D_IDLE;
            d_cnt   <= 0;
        end else begin
            case (d_state)
                D_IDLE: if (dv_valid) begin d_state <= D_BUSY; d_cnt <= LAT; end
                D_BUSY: if (d_cnt <= 1) d_state <= D_DONE; else d_cnt <= d_cnt - 1;
                D_DONE: d_state <= D_IDLE;
                default: d_state <= D_IDLE;
            endcase
        end
    end

    assign dv_ready     = (d_state == D_IDLE);
    assign dv_out_valid = (d_state == D_DONE);
    // Result recomputed from live operands, like the real divider in DONE
    always_comb {dv_quot, dv_rema} = div_model(dv_dividend, dv_divisor, dv_signed, dv_w);

    // Response monitor: pops the scoreboard on every resp handshake
    always @(negedge clk) begin : mon
        exp_t e;
        if (dv_valid) dv_cycles++;
        if (reset && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check_val("resp_unexpected", {63'd0, resp_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("resp_data", resp_data, e.data);
                check_val("resp_tag", {59'd0, resp_tag}, {59'd0, e.tag});
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_word = w;
        req_src1 = a; req_src2 = b; req_tag = tag;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_val("accept_timeout", {63'd0, req_ready}, 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back({exp, tag});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string p);
        check_val({p, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        check_val({p, "_resp_data"}, resp_data, 64'd0);
        check_val({p, "_resp_tag"}, {59'd0, resp_tag}, 64'd0);
        check_val({p, "_dv_valid"}, {63'd0, dv_valid}, 64'd0);
        check_val({p, "_dv_flush"}, {63'd0, dv_flush}, 64'd0);
        check_val({p, "_dv_signed"}, {63'd0, dv_signed}, 64'd0);
        check_val({p, "_dv_w"}, {63'd0, dv_w}, 64'd0);
        check_val({p, "_dv_dividend"}, dv_dividend, 64'd0);
        check_val({p, "_dv_divisor"}, dv_divisor, 64'd0);
        check_val({p, "_busy"}, {63'd0, busy}, 64'd0);
        check_val({p, "_req_ready"}, {63'd0, req_ready}, 64'd0);
    endtask

    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    initial begin : stim
        int d0;
        int n;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("req_ready_after_rst", {63'd0, req_ready}, 64'd1);

        // Signed divide through the divider, then REM on the same operands
        send(DIV, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        @(negedge clk);
        check_val("dv_valid_t1", {63'd0, dv_valid}, 64'd1);
        d0 = dv_cycles;
        send(REM, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 64'd2, 1'b1);
`ifdef YSYX_22041071_DIV_REUSE_EN
        @(negedge clk);
        check_val("reuse_lat", {63'd0, resp_valid}, 64'd1);
        check_val("reuse_no_launch", dv_cycles - d0, 64'd0);
`endif
        wait_idle();

        // Divide by zero resolved without the divider
        d0 = dv_cycles;
        send(DIVU, 1'b0, 64'h1234, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge clk);
        check_val("div0_lat", {63'd0, resp_valid}, 64'd1);
        check_val("div0_no_launch", dv_cycles - d0, 64'd0);
        send(REMU, 1'b0, 64'h1234, 64'd0, 5'd4, 64'h1234, 1'b1);

        // Signed overflow, 64-bit and W
        send(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,
             64'h8000_0000_0000_0000, 1'b1);
        send(REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd0, 1'b1);
        send(DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7,
             64'hFFFF_FFFF_8000_0000, 1'b1);
        wait_idle();
        check_val("ovf_no_launch", dv_cycles - d0, 64'd0);

        // W ops through the divider
        send(DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd8, 64'h0000_0000_7FFF_FFFF, 1'b1);
        send(REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle();

        // Flush ten cycles into WAIT
        send(DIV, 1'b0, 64'd50, 64'd7, 5'd10, 64'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check_val("flush_pulse", {63'd0, dv_flush}, 64'd1);
        check_val("flush_dv_valid", {63'd0, dv_valid}, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_val("flush_pulse_end", {63'd0, dv_flush}, 64'd0);
        check_val("drain_ready", {63'd0, req_ready}, 64'd0);
        check_val("drain_no_resp", {63'd0, resp_valid}, 64'd0);
        n = 0;
        while (!req_ready && n < 300) begin
            check_val("drain_dv_valid", {63'd0, dv_valid}, 64'd0);
            @(negedge clk);
            n++;
        end
        check_val("drain_waits_divider", {63'd0, n > 5}, 64'd1);
        send(DIVU, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 1'b1);
        wait_idle();

        // Flush in the first WAIT cycle
        send(DIV, 1'b0, 64'd50, 64'd7, 5'd12, 64'd0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check_val("flush1_pulse", {63'd0, dv_flush}, 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_val("flush1_drain", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check_val("flush1_exit", {63'd0, busy}, 64'd0);
        check_val("flush1_ready", {63'd0, req_ready}, 64'd1);

        // Back-pressure on the response
        @(posedge clk);
        #1 resp_ready = 1'b0;
        send(DIVU, 1'b0, 64'd1000, 64'd3, 5'd13, 64'd333, 1'b1);
        n = 0;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("hold_valid", {63'd0, resp_valid}, 64'd1);
            check_val("hold_data", resp_data, 64'd333);
            check_val("hold_tag", {59'd0, resp_tag}, 64'd13);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of WAIT
        send(DIV, 1'b0, 64'd50, 64'd7, 5'd14, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 reset = 1'b1;
        send(DIVU, 1'b0, 64'd100, 64'd7, 5'd15, 64'd14, 1'b1);
        wait_idle();

        check_val("sb_empty", sb_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
